// File: rtl/sawtooth_keystream_quantizer_if.sv
`default_nettype none
// ============================================================================
//  Module   : sawtooth_keystream_quantizer_if
//  Brief    : Streaming handshake bundle for the keystream quantizer: FP32
//             values in from the sawtooth stage, keystream bytes out to the
//             pixel XOR/diffusion stage.
//  Revision : 1.0 - initial release
// ============================================================================
interface sawtooth_keystream_quantizer_if #(
  parameter int PRECISION = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [PRECISION-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [7:0]           out_byte;

  // Environment side: produces values, consumes bytes
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_byte
  );

  // Quantizer side: consumes values, produces bytes
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_byte
  );
endinterface
`default_nettype wire

// File: rtl/sawtooth_keystream_quantizer.sv
`default_nettype none
// ============================================================================
//  Module   : sawtooth_keystream_quantizer
//  Brief    : Quantizes FP32 chaos values to keystream bytes,
//             byte = floor(|v| * 2^SCALE) mod 256, through a two-stage
//             pipeline into a credit-protected output FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
module sawtooth_keystream_quantizer #(
  parameter int PRECISION = 32,
  parameter int SCALE     = 20,
  parameter int DEPTH     = 4
) (
  input  wire logic                     clk,
  input  wire logic                     reset,
  sawtooth_keystream_quantizer_if.slave bus,
  output logic [$clog2(DEPTH):0]        level,
  output logic                          err_sticky
);

  localparam int                    c_AW       = $clog2(DEPTH);
  localparam logic [1:0]            c_CLS_ZERO = 2'd0;
  localparam logic [1:0]            c_CLS_NORM = 2'd1;
  localparam logic [1:0]            c_CLS_SPEC = 2'd2;
  // sh = e - 127 + SCALE - 23 folded into one bias
  localparam logic signed [9:0]     c_SH_BIAS  = 10'(SCALE - 150);
  localparam logic [c_AW+1:0]       c_DEPTH    = (c_AW+2)'(DEPTH);

  // Stage 1: decoded operand
  logic                r_s1_valid;
  logic [23:0]         r_s1_sig;
  logic signed [9:0]   r_s1_sh;
  logic [1:0]          r_s1_cls;
  // Stage 2: finished byte awaiting push
  logic                r_s2_valid;
  logic [7:0]          r_s2_byte;
  logic                r_s2_spec;
  // FIFO
  logic [7:0]          r_mem [DEPTH];
  logic [c_AW-1:0]     r_wr_ptr;
  logic [c_AW-1:0]     r_rd_ptr;
  logic [c_AW:0]       r_level;
  logic                r_err;

  logic [7:0]          w_exp;
  logic signed [9:0]   w_sh;
  logic [1:0]          w_cls;
  logic                w_accept;
  logic [7:0]          w_byte;
  logic signed [9:0]   w_neg_sh;
  logic [23:0]         w_shr;
  logic                w_push;
  logic                w_pop;
  logic [c_AW+1:0]     w_credit;
  logic                w_unused_sign;

  // Magnitude only: the sign bit never reaches the byte
  assign w_unused_sign = bus.in_data[PRECISION-1];
  assign w_exp         = bus.in_data[30:23];
  assign w_sh          = $signed({2'b00, w_exp}) + c_SH_BIAS;
  assign w_accept      = bus.in_valid && bus.in_ready;

  // Classify the incoming exponent; denormals collapse into zero
  always_comb begin
    w_cls = c_CLS_NORM;
    if (w_exp == 8'h00) begin
      w_cls = c_CLS_ZERO;
    end else if (w_exp == 8'hFF) begin
      w_cls = c_CLS_SPEC;
    end
  end

  // Stage 1 register: capture significand, shift amount and class
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_sig   <= 24'd0;
      r_s1_sh    <= 10'sd0;
      r_s1_cls   <= c_CLS_ZERO;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_sig <= {1'b1, bus.in_data[22:0]};
        r_s1_sh  <= w_sh;
        r_s1_cls <= w_cls;
      end
    end
  end

  // Byte extraction: left shift for small positive sh, right shift otherwise
  always_comb begin
    w_byte   = 8'h00;
    w_neg_sh = -r_s1_sh;
    w_shr    = r_s1_sig >> w_neg_sh[4:0];
    if (r_s1_cls == c_CLS_NORM) begin
      if (r_s1_sh >= 10'sd8) begin
        w_byte = 8'h00;
      end else if (r_s1_sh >= 10'sd0) begin
        w_byte = r_s1_sig[7:0] << r_s1_sh[2:0];
      end else if (r_s1_sh > -10'sd24) begin
        w_byte = w_shr[7:0];
      end
    end
  end

  // Stage 2 register: hold the byte and its special flag for the push edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_s2_byte  <= 8'h00;
      r_s2_spec  <= 1'b0;
    end else begin
      r_s2_valid <= r_s1_valid;
      r_s2_byte  <= w_byte;
      r_s2_spec  <= r_s1_valid && (r_s1_cls == c_CLS_SPEC);
    end
  end

  assign w_push = r_s2_valid;
  assign w_pop  = (r_level != '0) && bus.out_ready;

  // FIFO storage; contents are don't-care while unoccupied
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= r_s2_byte;
    end
  end

  // FIFO pointers, occupancy and sticky error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_push && r_s2_spec) begin
        r_err <= 1'b1;
      end
    end
  end

  // Credit check from registers only, so a same-cycle pop never frees a slot
  always_comb begin
    w_credit     = {1'b0, r_level}
                 + {{(c_AW+1){1'b0}}, r_s1_valid}
                 + {{(c_AW+1){1'b0}}, r_s2_valid};
    bus.in_ready = !reset && (w_credit < c_DEPTH);
  end

  assign bus.out_valid = (r_level != '0);
  assign bus.out_byte  = bus.out_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign level         = r_level;
  assign err_sticky    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sawtooth_keystream_quantizer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sawtooth_keystream_quantizer
//  Brief    : Directed self-checking bench for the keystream quantizer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sawtooth_keystream_quantizer;

  logic       clk;
  logic       reset;
  logic [2:0] level;
  logic       err_sticky;
  int         n_tests;
  int         n_fail;
  logic [31:0] vec_in  [8];
  logic [7:0]  vec_out [8];

  sawtooth_keystream_quantizer_if #(.PRECISION(32)) bus ();

  sawtooth_keystream_quantizer #(
    .PRECISION (32),
    .SCALE     (20),
    .DEPTH     (4)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .level      (level),
    .err_sticky (err_sticky)
  );

  // Free-running 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence never completes
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the head byte and pop it
  task automatic pop_expect(input string tag, input logic [7:0] exp);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_byte"}, 32'(bus.out_byte), 32'(exp));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  // Stream n values back-to-back with the consumer keeping up;
  // byte j must show on the cycle after edge N+2+j
  task automatic stream(input string tag, input int n);
    bus.out_ready = 1'b1;
    for (int k = 0; k < n + 3; k++) begin
      if (k < n) begin
        bus.in_valid = 1'b1;
        bus.in_data  = vec_in[k];
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
      if (k >= 2 && k < n + 2) begin
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_byte"}, 32'(bus.out_byte), 32'(vec_out[k-2]));
      end
      chk({tag, "_level_le1"}, 32'(level <= 3'd1), 32'd1);
    end
    bus.out_ready = 1'b0;
    tick();
    chk({tag, "_drained"}, 32'(level), 32'd0);
  endtask

  initial begin
    int acc;
    n_tests       = 0;
    n_fail        = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 32'd0;
    bus.out_ready = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_byte", 32'(bus.out_byte), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_err", 32'(err_sticky), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Single 0.05 -> 0xCC with latency 2, held while not popped
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h3D4CCCCD;
    tick();
    bus.in_valid = 1'b0;
    chk("t1_n_valid", 32'(bus.out_valid), 32'd0);
    tick();
    chk("t1_n1_valid", 32'(bus.out_valid), 32'd0);
    chk("t1_n1_byte", 32'(bus.out_byte), 32'd0);
    tick();
    chk("t1_n2_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_n2_byte", 32'(bus.out_byte), 32'hCC);
    chk("t1_n2_level", 32'(level), 32'd1);
    tick();
    tick();
    chk("t1_hold_byte", 32'(bus.out_byte), 32'hCC);
    chk("t1_hold_level", 32'(level), 32'd1);
    pop_expect("t1_pop", 8'hCC);
    chk("t1_empty_valid", 32'(bus.out_valid), 32'd0);
    chk("t1_empty_byte", 32'(bus.out_byte), 32'd0);

    // Back-to-back stream, order preserved
    vec_in[0] = 32'h3FE00000; vec_out[0] = 8'h00;
    vec_in[1] = 32'h3F4CCCCD; vec_out[1] = 8'hCC;
    vec_in[2] = 32'h00000000; vec_out[2] = 8'h00;
    vec_in[3] = 32'h3D4CCCCD; vec_out[3] = 8'hCC;
    stream("t2", 4);

    // Backpressure: exactly DEPTH accepted, no same-cycle credit on pop
    acc = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h3D4CCCCD;
    for (int c = 0; c < 10; c++) begin
      if (bus.in_valid && bus.in_ready) acc++;
      tick();
    end
    bus.in_valid = 1'b0;
    chk("t3_accepted", 32'(acc), 32'd4);
    chk("t3_full_ready", 32'(bus.in_ready), 32'd0);
    chk("t3_full_level", 32'(level), 32'd4);
    bus.out_ready = 1'b1;
    #1;
    chk("t3_pop_cycle_ready", 32'(bus.in_ready), 32'd0);
    tick();
    bus.out_ready = 1'b0;
    chk("t3_after_pop_level", 32'(level), 32'd3);
    chk("t3_after_pop_ready", 32'(bus.in_ready), 32'd1);
    pop_expect("t3_d1", 8'hCC);
    pop_expect("t3_d2", 8'hCC);
    pop_expect("t3_d3", 8'hCC);
    chk("t3_drained", 32'(level), 32'd0);

    // Specials and a negative operand
    vec_in[0] = 32'h7F800000;
    vec_in[1] = 32'h7FC00000;
    vec_in[2] = 32'hBD4CCCCD;
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = (k < 3);
      bus.in_data  = (k < 3) ? vec_in[k] : 32'd0;
      tick();
      if (k == 1) chk("t4_err_before_push", 32'(err_sticky), 32'd0);
      if (k == 2) chk("t4_err_first_push", 32'(err_sticky), 32'd1);
    end
    chk("t4_level", 32'(level), 32'd3);
    pop_expect("t4_inf", 8'h00);
    pop_expect("t4_nan", 8'h00);
    pop_expect("t4_neg", 8'hCC);
    chk("t4_err_stays", 32'(err_sticky), 32'd1);

    // Shift boundaries around sh = 8, 7, 0, -23, -24 plus denormal
    vec_in[0] = 32'h45000000; vec_out[0] = 8'h00;  // sh = 8
    vec_in[1] = 32'h44FFFFFF; vec_out[1] = 8'h80;  // sh = 7
    vec_in[2] = 32'h410000AB; vec_out[2] = 8'hAB;  // sh = 0
    vec_in[3] = 32'h35800000; vec_out[3] = 8'h01;  // sh = -23
    vec_in[4] = 32'h35000000; vec_out[4] = 8'h00;  // sh = -24
    vec_in[5] = 32'h00000001; vec_out[5] = 8'h00;  // denormal
    vec_in[6] = 32'h4B000000; vec_out[6] = 8'h00;  // 2^23
    vec_in[7] = 32'h33800000; vec_out[7] = 8'h00;  // 2^-24
    stream("t5", 8);

    // Reset with bytes buffered and values in flight
    bus.in_data = 32'h3D4CCCCD;
    for (int k = 0; k < 4; k++) begin
      bus.in_valid = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    chk("t6_pre_level", 32'(level), 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_level", 32'(level), 32'd0);
    chk("t6_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_err", 32'(err_sticky), 32'd0);
    chk("t6_byte", 32'(bus.out_byte), 32'd0);
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus.out_valid) acc++;
    end
    chk("t6_no_stale", 32'(acc), 32'd0);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("t6_n1_valid", 32'(bus.out_valid), 32'd0);
    tick();
    chk("t6_n2_valid", 32'(bus.out_valid), 32'd1);
    chk("t6_n2_byte", 32'(bus.out_byte), 32'hCC);
    chk("t6_err_clear", 32'(err_sticky), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
